// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared decode constants and source-register helpers for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam int FIELD_W = 5;
    localparam int OPC_MSB = 31;
    localparam int RD_MSB  = 26;
    localparam int RS_MSB  = 21;
    localparam int RT_MSB  = 16;
    localparam int ALU_MSB = 6;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Jumps and setx carry no rs operand.
    function automatic logic uses_rs(input logic [4:0] op);
        return !(op inside {OP_J, OP_JAL, OP_SETX});
    endfunction

    function automatic logic uses_rt(input logic [4:0] op);
        return op == OP_RTYPE;
    endfunction

    // Stores and register-compare branches read rd as a source.
    function automatic logic uses_rd(input logic [4:0] op);
        return op inside {OP_SW, OP_BNE, OP_BLT, OP_JR};
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_stall_fsm.sv
// Mult/div stall sequencer: holds the pipe while a mul/div sits in X, with a watchdog.
//
//  state    | meaning
//  MD_IDLE  | no mult/div outstanding; a mul/div arriving in D/X launches the unit
//  MD_BUSY  | waiting for the result; the MD_MAX_CYCLES-th busy cycle is forced to release
module md_stall_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 40
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic md_req_i,
    input  logic md_result_ready_i,
    output logic md_stall_o,
    output logic md_start_o,
    output logic md_timeout_o
);

    localparam int              WD_W    = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_MAX_CYCLES - 1);

    md_state_e       state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    // State, watchdog and sticky timeout registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= MD_IDLE;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state and stall/start decode; md_start is masked while reset is held.
    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        timeout_d  = timeout_q;
        md_stall_o = 1'b0;
        md_start_o = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_req_i) begin
                    md_stall_o = 1'b1;
                    md_start_o = !reset_i;
                    wd_d       = '0;
                    state_d    = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = MD_IDLE;
                end else if (md_result_ready_i) begin
                    state_d   = MD_IDLE;
                end else begin
                    md_stall_o = 1'b1;
                    wd_d       = wd_q + WD_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign md_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, branch squash, stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int          MD_MAX_CYCLES = 40,
    parameter logic [31:0] NOP           = 32'h00000000,
    parameter int          CNT_W         = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [31:0]      fd_insn_i,
    input  logic [31:0]      dx_insn_i,
    input  logic             branch_taken_i,
    input  logic             md_result_ready_i,
    output logic             pc_we_o,
    output logic             fd_we_o,
    output logic             dx_we_o,
    output logic             xm_we_o,
    output logic             fd_flush_o,
    output logic             dx_flush_o,
    output logic             md_start_o,
    output logic             md_timeout_o,
    output logic [CNT_W-1:0] stall_count_o
);

    logic [4:0]       fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0]       dx_op, dx_rd, dx_aluop;
    logic             dx_is_md, load_use, md_stall;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // NOP is applied by the datapath muxes; only the flush strobes come from here.
    logic unused_ok;
    assign unused_ok = ^{NOP, fd_insn_i[11:0], dx_insn_i[21:7], dx_insn_i[1:0]};

    assign fd_op    = fd_insn_i[OPC_MSB -: FIELD_W];
    assign fd_rd    = fd_insn_i[RD_MSB  -: FIELD_W];
    assign fd_rs    = fd_insn_i[RS_MSB  -: FIELD_W];
    assign fd_rt    = fd_insn_i[RT_MSB  -: FIELD_W];
    assign dx_op    = dx_insn_i[OPC_MSB -: FIELD_W];
    assign dx_rd    = dx_insn_i[RD_MSB  -: FIELD_W];
    assign dx_aluop = dx_insn_i[ALU_MSB -: FIELD_W];

    assign dx_is_md = (dx_op == OP_RTYPE) && (dx_aluop inside {ALU_MUL, ALU_DIV});

    assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                      ((uses_rs(fd_op) && (fd_rs == dx_rd)) ||
                       (uses_rt(fd_op) && (fd_rt == dx_rd)) ||
                       (uses_rd(fd_op) && (fd_rd == dx_rd)));

    md_stall_fsm #(
        .MD_MAX_CYCLES (MD_MAX_CYCLES)
    ) u_md_fsm (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .md_req_i          (dx_is_md),
        .md_result_ready_i (md_result_ready_i),
        .md_stall_o        (md_stall),
        .md_start_o        (md_start_o),
        .md_timeout_o      (md_timeout_o)
    );

    // Enable/flush priority: mult/div stall, then branch squash, then load-use bubble.
    always_comb begin
        pc_we_o    = 1'b1;
        fd_we_o    = 1'b1;
        dx_we_o    = 1'b1;
        xm_we_o    = 1'b1;
        fd_flush_o = 1'b0;
        dx_flush_o = 1'b0;
        if (md_stall) begin
            pc_we_o = 1'b0;
            fd_we_o = 1'b0;
            dx_we_o = 1'b0;
            xm_we_o = 1'b0;
        end else if (branch_taken_i) begin
            fd_flush_o = 1'b1;
            dx_flush_o = 1'b1;
        end else if (load_use) begin
            pc_we_o    = 1'b0;
            fd_we_o    = 1'b0;
            dx_flush_o = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MAXC = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fd_insn = '0;
    logic [31:0] dx_insn = '0;
    logic        bt = 1'b0;
    logic        rdy = 1'b0;
    logic        pc_we, fd_we, dx_we, xm_we, fd_flush, dx_flush, md_start, md_timeout;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;
    int n_start = 0;

    // behavioural model state
    bit m_busy = 0;
    int m_waited = 0;
    bit m_to = 0;
    int m_cnt = 0;

    pipe_hazard_ctrl dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .fd_insn_i         (fd_insn),
        .dx_insn_i         (dx_insn),
        .branch_taken_i    (bt),
        .md_result_ready_i (rdy),
        .pc_we_o           (pc_we),
        .fd_we_o           (fd_we),
        .dx_we_o           (dx_we),
        .xm_we_o           (xm_we),
        .fd_flush_o        (fd_flush),
        .dx_flush_o        (dx_flush),
        .md_start_o        (md_start),
        .md_timeout_o      (md_timeout),
        .stall_count_o     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt, input int alu);
        logic [31:0] w;
        w = '0;
        w[31:27] = op[4:0];
        w[26:22] = rd[4:0];
        w[21:17] = rs[4:0];
        w[16:12] = rt[4:0];
        w[6:2]   = alu[4:0];
        return w;
    endfunction

    function automatic bit is_md(input logic [31:0] dx);
        return dx[31:27] == 5'd0 && (dx[6:2] == 5'd6 || dx[6:2] == 5'd7);
    endfunction

    function automatic bit lu_hazard(input logic [31:0] fd, input logic [31:0] dx);
        int srcs[$];
        int op;
        op = int'(fd[31:27]);
        if (dx[31:27] != 5'd8 || dx[26:22] == 5'd0) return 0;
        if (op != 1 && op != 3 && op != 21) srcs.push_back(int'(fd[21:17]));
        if (op == 0) srcs.push_back(int'(fd[16:12]));
        if (op == 7 || op == 2 || op == 6 || op == 4) srcs.push_back(int'(fd[26:22]));
        foreach (srcs[i]) if (srcs[i] == int'(dx[26:22])) return 1;
        return 0;
    endfunction

    // One clock cycle: drive, compare against the model, then advance the model past the edge.
    task automatic cycle(input logic [31:0] fd, input logic [31:0] dx, input logic b, input logic r, input logic rs);
        bit stall_md, last_busy, e_pc, e_fd, e_dx, e_xm, e_ff, e_df, e_st;
        @(posedge clk);
        #1;
        fd_insn = fd; dx_insn = dx; bt = b; rdy = r; rst = rs;
        #1;
        if (rs) begin
            m_busy = 0; m_waited = 0; m_to = 0; m_cnt = 0;
        end
        last_busy = m_busy && (m_waited + 1 >= MAXC);
        stall_md = (!m_busy && is_md(dx)) || (m_busy && !r && !last_busy);
        e_pc = 1; e_fd = 1; e_dx = 1; e_xm = 1; e_ff = 0; e_df = 0;
        if (stall_md) begin
            e_pc = 0; e_fd = 0; e_dx = 0; e_xm = 0;
        end else if (b) begin
            e_ff = 1; e_df = 1;
        end else if (lu_hazard(fd, dx)) begin
            e_pc = 0; e_fd = 0; e_df = 1;
        end
        e_st = !m_busy && is_md(dx) && !rs;
        check("ctl", {24'd0, pc_we, fd_we, dx_we, xm_we, fd_flush, dx_flush, md_start, md_timeout},
                     {24'd0, e_pc, e_fd, e_dx, e_xm, e_ff, e_df, e_st, m_to});
        check("stall_cnt", {16'd0, stall_count}, m_cnt);
        if (md_start) n_start++;
        if (!rs) begin
            if (!m_busy) begin
                if (is_md(dx)) begin
                    m_busy = 1; m_waited = 0;
                end
            end else begin
                m_waited++;
                if (m_waited >= MAXC) begin
                    m_to = 1; m_busy = 0;
                end else if (r) begin
                    m_busy = 0;
                end
            end
            if (!e_pc && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic do_reset();
        cycle('0, '0, 0, 0, 1);
        cycle('0, '0, 0, 0, 1);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [4:0] ops [10];
        int op;
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd21, 5'd8};
        if ($urandom_range(0, 19) == 0)
            return mk(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(6, 7));
        op = int'(ops[$urandom_range(0, 9)]);
        return mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5));
    endfunction

    initial begin
        logic [31:0] add_r3, lw_r5, lw_r0, add_r0, mul1, mul2, div1;
        int c0;
        add_r3 = mk(0, 3, 5, 2, 0);
        lw_r5  = mk(8, 5, 1, 0, 0);
        lw_r0  = mk(8, 0, 1, 0, 0);
        add_r0 = mk(0, 4, 0, 0, 0);
        mul1   = mk(0, 6, 1, 2, 6);
        mul2   = mk(0, 7, 3, 4, 6);
        div1   = mk(0, 8, 1, 2, 7);

        // reset state
        do_reset();
        cycle(add_r3, mk(0, 9, 10, 11, 0), 0, 0, 0);
        check("rst_pc_we", {31'd0, pc_we}, 1);
        check("rst_cnt", {16'd0, stall_count}, 0);

        // load-use: one bubble, then normal; rd=r0 never stalls
        cycle(add_r3, lw_r5, 0, 0, 0);
        check("lu_pc_we", {31'd0, pc_we}, 0);
        check("lu_dx_flush", {31'd0, dx_flush}, 1);
        cycle(add_r3, '0, 0, 0, 0);
        check("lu_after", {31'd0, pc_we}, 1);
        cycle(add_r0, lw_r0, 0, 0, 0);
        check("lu_r0", {31'd0, pc_we}, 1);

        // mul with ready after 33 stalled busy cycles
        do_reset();
        n_start = 0;
        cycle('0, mul1, 0, 0, 0);
        for (int i = 0; i < 33; i++) cycle('0, mul1, 0, 0, 0);
        cycle('0, mul1, 0, 1, 0);
        check("md_release_we", {28'd0, pc_we, fd_we, dx_we, xm_we}, 4'hf);
        cycle('0, '0, 0, 0, 0);
        check("md_stall_cnt", {16'd0, stall_count}, 34);
        check("md_starts", n_start, 1);

        // branch with a load-use hazard in the same cycle
        cycle(add_r3, lw_r5, 1, 0, 0);
        check("br_flush", {30'd0, fd_flush, dx_flush}, 2'b11);
        check("br_pc_we", {31'd0, pc_we}, 1);

        // div with no ready: watchdog timeout, sticky
        do_reset();
        cycle('0, div1, 0, 0, 0);
        for (int i = 0; i < MAXC; i++) cycle('0, div1, 0, 0, 0);
        cycle('0, '0, 0, 0, 0);
        check("to_set", {31'd0, md_timeout}, 1);
        check("to_cnt", {16'd0, stall_count}, MAXC);
        for (int i = 0; i < 5; i++) cycle(add_r3, '0, 0, 0, 0);
        check("to_sticky", {31'd0, md_timeout}, 1);

        // back-to-back mul
        do_reset();
        n_start = 0;
        cycle('0, mul1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle('0, mul1, 0, 0, 0);
        cycle('0, mul1, 0, 1, 0);
        cycle('0, mul2, 0, 0, 0);
        check("b2b_start2", {31'd0, md_start}, 1);
        for (int i = 0; i < 2; i++) cycle('0, mul2, 0, 0, 0);
        cycle('0, mul2, 0, 1, 0);
        cycle('0, '0, 0, 0, 0);
        check("b2b_starts", n_start, 2);

        // reset mid-busy: no start glitch, back to idle decode
        cycle('0, mul1, 0, 0, 0);
        cycle('0, mul1, 0, 0, 0);
        cycle(add_r3, mul1, 0, 0, 1);
        check("rst_mid_start", {31'd0, md_start}, 0);
        cycle(add_r3, '0, 0, 0, 1);
        cycle(add_r3, '0, 0, 0, 0);
        check("rst_mid_we", {31'd0, pc_we}, 1);

        // random traffic
        c0 = checks;
        for (int i = 0; i < 3000; i++) begin
            cycle(rand_insn(), rand_insn(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 299) == 0));
        end
        check("rand_ran", checks - c0, 6000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
